// File: rtl/avalon_xbar_arb.sv
// N x M Avalon-MM crossbar: each slave port decodes its masters from the upper
// address bits and arbitrates them round-robin, holding the grant for a whole burst.
module avalon_xbar_arb #(
    parameter int NUM_INPUTS  = 5,
    parameter int NUM_OUTPUTS = 5,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int BURST_W     = 8
) (
    input  logic                            i_Clk,
    input  logic                            i_Reset,
    input  logic [ADDR_W*NUM_INPUTS-1:0]    i_AVIn_Addr,
    input  logic [(DATA_W/8)*NUM_INPUTS-1:0] i_AVIn_ByteEn,
    input  logic [NUM_INPUTS-1:0]           i_AVIn_Read,
    input  logic [NUM_INPUTS-1:0]           i_AVIn_Write,
    input  logic [DATA_W*NUM_INPUTS-1:0]    i_AVIn_WriteData,
    input  logic [BURST_W*NUM_INPUTS-1:0]   i_AVIn_BurstCount,
    output logic [DATA_W*NUM_INPUTS-1:0]    o_AVIn_ReadData,
    output logic [NUM_INPUTS-1:0]           o_AVIn_WaitRequest,
    output logic [NUM_INPUTS-1:0]           o_DecodeErr,
    output logic [ADDR_W*NUM_OUTPUTS-1:0]   o_AVOut_Addr,
    output logic [(DATA_W/8)*NUM_OUTPUTS-1:0] o_AVOut_ByteEn,
    output logic [NUM_OUTPUTS-1:0]          o_AVOut_Read,
    output logic [NUM_OUTPUTS-1:0]          o_AVOut_Write,
    output logic [DATA_W*NUM_OUTPUTS-1:0]   o_AVOut_WriteData,
    output logic [BURST_W*NUM_OUTPUTS-1:0]  o_AVOut_BurstCount,
    input  logic [DATA_W*NUM_OUTPUTS-1:0]   i_AVOut_ReadData,
    input  logic [NUM_OUTPUTS-1:0]          i_AVOut_WaitRequest
);

    localparam int SEL_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_q    [NUM_OUTPUTS];
    logic [IDX_W-1:0]     grant_q    [NUM_OUTPUTS];
    logic [IDX_W-1:0]     rr_ptr_q   [NUM_OUTPUTS];
    logic [BURST_W-1:0]   beat_cnt_q [NUM_OUTPUTS];

    logic [SEL_W-1:0]      dec_s   [NUM_INPUTS];
    logic [SEL_W-1:0]      gout_s  [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] active_s;
    logic [NUM_INPUTS-1:0] mapped_s;
    logic [NUM_INPUTS-1:0] granted_s;

    logic [NUM_INPUTS-1:0]  req_s  [NUM_OUTPUTS];
    logic [IDX_W:0]         pick_s [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] route_ok_s;
    logic [NUM_OUTPUTS-1:0] accept_s;
    logic [NUM_OUTPUTS-1:0] release_s;

    // Scan backwards so the requester closest to ptr is assigned last and wins.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_INPUTS-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int             cand;
        res = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            cand = (cand >= NUM_INPUTS) ? cand - NUM_INPUTS : cand;
            res  = req[cand] ? {1'b1, IDX_W'(cand)} : res;
        end
        return res;
    endfunction

    // Per-master address decode and activity.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            dec_s[i]    = i_AVIn_Addr[i*ADDR_W + ADDR_W - SEL_W +: SEL_W];
            active_s[i] = i_AVIn_Read[i] | i_AVIn_Write[i];
            mapped_s[i] = (int'(dec_s[i]) < NUM_OUTPUTS);
        end
    end

    // Which output (if any) currently owns each master.
    always_comb begin
        granted_s = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            gout_s[i] = '0;
        end
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                granted_s[i] = granted_s[i] |
                               ((state_q[o] == ST_LOCKED) && (int'(grant_q[o]) == i));
                gout_s[i]    = ((state_q[o] == ST_LOCKED) && (int'(grant_q[o]) == i)) ?
                               SEL_W'(o) : gout_s[i];
            end
        end
    end

    // Request matrix, round-robin pick, and beat/release qualification per output.
    always_comb begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                req_s[o][i] = active_s[i] & mapped_s[i] & ~granted_s[i] &
                              (dec_s[i] == SEL_W'(o));
            end
            pick_s[o]     = rr_pick(req_s[o], rr_ptr_q[o]);
            // Strobes only pass while the owner still decodes to this output.
            route_ok_s[o] = (state_q[o] == ST_LOCKED) && !i_Reset &&
                            (dec_s[grant_q[o]] == SEL_W'(o));
            accept_s[o]   = route_ok_s[o] & active_s[grant_q[o]] & ~i_AVOut_WaitRequest[o];
            release_s[o]  = (state_q[o] == ST_LOCKED) &&
                            ((accept_s[o] && (beat_cnt_q[o] == BURST_W'(1))) ||
                             !active_s[grant_q[o]]);
        end
    end

    // Per-output arbitration FSM: grant, burst countdown, release.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                state_q[o]    <= ST_IDLE;
                grant_q[o]    <= '0;
                rr_ptr_q[o]   <= '0;
                beat_cnt_q[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                case (state_q[o])
                    ST_IDLE: begin
                        if (pick_s[o][IDX_W]) begin
                            state_q[o]    <= ST_LOCKED;
                            grant_q[o]    <= pick_s[o][IDX_W-1:0];
                            beat_cnt_q[o] <=
                                (i_AVIn_BurstCount[int'(pick_s[o][IDX_W-1:0])*BURST_W +: BURST_W] == '0) ?
                                BURST_W'(1) :
                                i_AVIn_BurstCount[int'(pick_s[o][IDX_W-1:0])*BURST_W +: BURST_W];
                        end else begin
                            state_q[o] <= ST_IDLE;
                        end
                    end
                    ST_LOCKED: begin
                        if (release_s[o]) begin
                            state_q[o]    <= ST_IDLE;
                            beat_cnt_q[o] <= '0;
                            rr_ptr_q[o]   <= (int'(grant_q[o]) == NUM_INPUTS - 1) ?
                                             IDX_W'(0) : grant_q[o] + IDX_W'(1);
                        end else if (accept_s[o]) begin
                            beat_cnt_q[o] <= beat_cnt_q[o] - BURST_W'(1);
                        end else begin
                            beat_cnt_q[o] <= beat_cnt_q[o];
                        end
                    end
                    default: begin
                        state_q[o] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Slave-side routing from the granted master.
    always_comb begin
        o_AVOut_Addr       = '0;
        o_AVOut_ByteEn     = '0;
        o_AVOut_Read       = '0;
        o_AVOut_Write      = '0;
        o_AVOut_WriteData  = '0;
        o_AVOut_BurstCount = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            if ((state_q[o] == ST_LOCKED) && !i_Reset) begin
                o_AVOut_Addr[o*ADDR_W +: ADDR_W] =
                    i_AVIn_Addr[int'(grant_q[o])*ADDR_W +: ADDR_W];
                o_AVOut_ByteEn[o*BE_W +: BE_W] =
                    i_AVIn_ByteEn[int'(grant_q[o])*BE_W +: BE_W];
                o_AVOut_WriteData[o*DATA_W +: DATA_W] =
                    i_AVIn_WriteData[int'(grant_q[o])*DATA_W +: DATA_W];
                o_AVOut_BurstCount[o*BURST_W +: BURST_W] =
                    i_AVIn_BurstCount[int'(grant_q[o])*BURST_W +: BURST_W];
                o_AVOut_Read[o]  = i_AVIn_Read[grant_q[o]] & route_ok_s[o];
                o_AVOut_Write[o] = i_AVIn_Write[grant_q[o]] & route_ok_s[o];
            end else begin
                o_AVOut_Read[o]  = 1'b0;
                o_AVOut_Write[o] = 1'b0;
            end
        end
    end

    // Master-side response: unmapped beats complete at once, others follow the owner.
    always_comb begin
        o_AVIn_ReadData    = '0;
        o_AVIn_WaitRequest = '1;
        o_DecodeErr        = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (i_Reset) begin
                o_AVIn_WaitRequest[i] = 1'b1;
            end else if (active_s[i] && !mapped_s[i]) begin
                o_AVIn_WaitRequest[i] = 1'b0;
                o_DecodeErr[i]        = 1'b1;
            end else if (granted_s[i]) begin
                o_AVIn_WaitRequest[i] = i_AVOut_WaitRequest[gout_s[i]];
                o_AVIn_ReadData[i*DATA_W +: DATA_W] =
                    i_AVOut_ReadData[int'(gout_s[i])*DATA_W +: DATA_W];
            end else begin
                o_AVIn_WaitRequest[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_xbar_arb.sv
// Directed bench for avalon_xbar_arb: expectations are queued as stimulus is
// applied and popped against the DUT outputs on the falling clock edge.
module tb_avalon_xbar_arb;

    localparam int NI  = 5;
    localparam int NO  = 5;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int BW  = 8;
    localparam int BEW = DW / 8;

    logic clk;
    logic rst;

    logic [AW*NI-1:0]  m_addr;
    logic [BEW*NI-1:0] m_be;
    logic [NI-1:0]     m_rd;
    logic [NI-1:0]     m_wr;
    logic [DW*NI-1:0]  m_wd;
    logic [BW*NI-1:0]  m_bc;
    logic [DW*NI-1:0]  m_rdata;
    logic [NI-1:0]     m_wait;
    logic [NI-1:0]     m_derr;

    logic [AW*NO-1:0]  s_addr;
    logic [BEW*NO-1:0] s_be;
    logic [NO-1:0]     s_rd;
    logic [NO-1:0]     s_wr;
    logic [DW*NO-1:0]  s_wd;
    logic [BW*NO-1:0]  s_bc;
    logic [DW*NO-1:0]  s_rdata;
    logic [NO-1:0]     s_wait;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;

    avalon_xbar_arb #(
        .NUM_INPUTS (NI),
        .NUM_OUTPUTS(NO),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .BURST_W    (BW)
    ) dut (
        .i_Clk              (clk),
        .i_Reset            (rst),
        .i_AVIn_Addr        (m_addr),
        .i_AVIn_ByteEn      (m_be),
        .i_AVIn_Read        (m_rd),
        .i_AVIn_Write       (m_wr),
        .i_AVIn_WriteData   (m_wd),
        .i_AVIn_BurstCount  (m_bc),
        .o_AVIn_ReadData    (m_rdata),
        .o_AVIn_WaitRequest (m_wait),
        .o_DecodeErr        (m_derr),
        .o_AVOut_Addr       (s_addr),
        .o_AVOut_ByteEn     (s_be),
        .o_AVOut_Read       (s_rd),
        .o_AVOut_Write      (s_wr),
        .o_AVOut_WriteData  (s_wd),
        .o_AVOut_BurstCount (s_bc),
        .i_AVOut_ReadData   (s_rdata),
        .i_AVOut_WaitRequest(s_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_m(input int i, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [BW-1:0] bc);
        m_rd[i]            = rd;
        m_wr[i]            = wr;
        m_addr[i*AW +: AW] = a;
        m_wd[i*DW +: DW]   = wd;
        m_bc[i*BW +: BW]   = bc;
        m_be[i*BEW +: BEW] = 4'hF;
    endtask

    task automatic set_s(input int o, input logic w, input logic [DW-1:0] rd);
        s_wait[o]           = w;
        s_rdata[o*DW +: DW] = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: observed=%h expected=queued value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    int gseq2 [8]  = '{-1, 0, -1, 1, -1, 3, -1, 0};
    int gseq3 [10] = '{-1, 1, 1, 1, 1, 1, 1, 1, -1, 2};
    logic sw3 [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        int g;
        rst     = 1'b1;
        m_addr  = '0;
        m_be    = '0;
        m_rd    = '0;
        m_wr    = '0;
        m_wd    = '0;
        m_bc    = '0;
        s_rdata = '0;
        s_wait  = '0;
        repeat (2) next_cycle();

        // Reset values while reset is held and right after release.
        expect_v("rst_wait", 32'h1F);
        expect_v("rst_rd", 32'h0);
        expect_v("rst_derr", 32'h0);
        @(negedge clk);
        check(32'(m_wait));
        check(32'(s_rd));
        check(32'(m_derr));
        next_cycle();
        rst = 1'b0;
        expect_v("post_rst_wait", 32'h1F);
        expect_v("post_rst_wr", 32'h0);
        @(negedge clk);
        check(32'(m_wait));
        check(32'(s_wr));

        // Single read M0 -> output 2.
        next_cycle();
        set_m(0, 1'b1, 1'b0, 30'h1000_0004, 32'h0, 8'd1);
        set_s(2, 1'b0, 32'hCAFE_F00D);
        expect_v("t1_c0_wait0", 32'h1);
        expect_v("t1_c0_rd2", 32'h0);
        @(negedge clk);
        check(32'(m_wait[0]));
        check(32'(s_rd[2]));
        next_cycle();
        expect_v("t1_c1_wait0", 32'h0);
        expect_v("t1_c1_rdata0", 32'hCAFE_F00D);
        expect_v("t1_c1_rd2", 32'h1);
        expect_v("t1_c1_addr2", 32'h1000_0004);
        @(negedge clk);
        check(32'(m_wait[0]));
        check(m_rdata[0 +: DW]);
        check(32'(s_rd[2]));
        check(32'(s_addr[2*AW +: AW]));
        next_cycle();
        expect_v("t1_c2_rd2", 32'h0);
        expect_v("t1_c2_wait0", 32'h1);
        @(negedge clk);
        check(32'(s_rd[2]));
        check(32'(m_wait[0]));
        next_cycle();
        set_m(0, 1'b0, 1'b0, 30'h0, 32'h0, 8'd0);
        next_cycle();

        // Round-robin among M0, M1, M3 on output 0.
        next_cycle();
        set_m(0, 1'b0, 1'b1, 30'h0, 32'hA000_0000, 8'd1);
        set_m(1, 1'b0, 1'b1, 30'h4, 32'hA000_0001, 8'd1);
        set_m(3, 1'b0, 1'b1, 30'h8, 32'hA000_0003, 8'd1);
        set_s(0, 1'b0, 32'h0);
        for (int c = 0; c < 8; c++) begin
            g = gseq2[c];
            expect_v("rr_wait", (g < 0) ? 32'h1F : (32'h1F & ~(32'h1 << g)));
            expect_v("rr_wr0", (g < 0) ? 32'h0 : 32'h1);
            if (g >= 0) expect_v("rr_wd0", 32'hA000_0000 + 32'(g));
        end
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            check(32'(m_wait));
            check(32'(s_wr[0]));
            if (gseq2[c] >= 0) check(s_wd[0 +: DW]);
        end
        next_cycle();
        m_wr = '0;
        m_rd = '0;
        next_cycle();

        // Burst lock: M1 burst of 4 on output 1, M2 waits; slave stalls beat 2.
        next_cycle();
        set_m(1, 1'b0, 1'b1, 30'h0800_0000, 32'hB000_0001, 8'd4);
        set_m(2, 1'b0, 1'b1, 30'h0800_0010, 32'hB000_0002, 8'd1);
        for (int c = 0; c < 10; c++) begin
            g = gseq3[c];
            expect_v("burst_wait1", (g == 1) ? 32'(sw3[c]) : 32'h1);
            expect_v("burst_wait2", (g == 2) ? 32'(sw3[c]) : 32'h1);
            expect_v("burst_wr1", (g < 0) ? 32'h0 : 32'h1);
        end
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            set_s(1, sw3[c], 32'h0);
            if (c == 8) set_m(1, 1'b0, 1'b0, 30'h0, 32'h0, 8'd0);
            @(negedge clk);
            check(32'(m_wait[1]));
            check(32'(m_wait[2]));
            check(32'(s_wr[1]));
        end
        next_cycle();
        set_m(2, 1'b0, 1'b0, 30'h0, 32'h0, 8'd0);
        next_cycle();

        // BurstCount of zero behaves as a single beat.
        next_cycle();
        set_m(0, 1'b0, 1'b1, 30'h0800_0000, 32'hC000_0000, 8'd0);
        expect_v("bc0_c0_wr1", 32'h0);
        expect_v("bc0_c1_wr1", 32'h1);
        expect_v("bc0_c1_wait0", 32'h0);
        expect_v("bc0_c2_wr1", 32'h0);
        @(negedge clk);
        check(32'(s_wr[1]));
        next_cycle();
        @(negedge clk);
        check(32'(s_wr[1]));
        check(32'(m_wait[0]));
        next_cycle();
        @(negedge clk);
        check(32'(s_wr[1]));
        next_cycle();
        set_m(0, 1'b0, 1'b0, 30'h0, 32'h0, 8'd0);
        next_cycle();

        // Parallel M0->out0 and M4->out4, M2 unmapped burst of 2.
        next_cycle();
        set_m(0, 1'b1, 1'b0, 30'h0000_0004, 32'h0, 8'd1);
        set_m(4, 1'b1, 1'b0, 30'h2000_0008, 32'h0, 8'd1);
        set_m(2, 1'b1, 1'b0, 30'h3000_0000, 32'h0, 8'd2);
        set_s(0, 1'b0, 32'h1111_1111);
        set_s(4, 1'b0, 32'h4444_4444);
        expect_v("par_c0_wait", 32'h1B);
        expect_v("par_c0_derr", 32'h04);
        expect_v("par_c0_rdata2", 32'h0);
        expect_v("par_c0_rd", 32'h0);
        expect_v("par_c1_wait", 32'h0A);
        expect_v("par_c1_derr", 32'h04);
        expect_v("par_c1_rdata0", 32'h1111_1111);
        expect_v("par_c1_rdata4", 32'h4444_4444);
        expect_v("par_c1_rd", 32'h11);
        expect_v("par_c1_addr4", 32'h2000_0008);
        expect_v("par_c2_rd", 32'h0);
        expect_v("par_c2_wait", 32'h1F);
        expect_v("par_c2_derr", 32'h0);
        @(negedge clk);
        check(32'(m_wait));
        check(32'(m_derr));
        check(m_rdata[2*DW +: DW]);
        check(32'(s_rd));
        next_cycle();
        @(negedge clk);
        check(32'(m_wait));
        check(32'(m_derr));
        check(m_rdata[0 +: DW]);
        check(m_rdata[4*DW +: DW]);
        check(32'(s_rd));
        check(32'(s_addr[4*AW +: AW]));
        next_cycle();
        set_m(2, 1'b0, 1'b0, 30'h0, 32'h0, 8'd0);
        @(negedge clk);
        check(32'(s_rd));
        check(32'(m_wait));
        check(32'(m_derr));
        next_cycle();
        m_rd = '0;
        m_wr = '0;
        next_cycle();

        // Reset during beat 3 of an 8-beat burst, then fresh arbitration from ptr 0.
        next_cycle();
        set_m(0, 1'b0, 1'b1, 30'h0, 32'hE000_0000, 8'd8);
        set_s(0, 1'b0, 32'h0);
        expect_v("rb_c1_wr0", 32'h1);
        expect_v("rb_post_wr", 32'h0);
        expect_v("rb_post_wait", 32'h1F);
        expect_v("rb_post_derr", 32'h0);
        expect_v("rb_post_addr0", 32'h0);
        expect_v("rb_m0_wait", 32'h1E);
        expect_v("rb_m0_wd0", 32'hE000_0000);
        expect_v("rb_abort_wr0", 32'h0);
        expect_v("rb_idle_wait", 32'h1F);
        expect_v("rb_m3_wait", 32'h17);
        expect_v("rb_m3_wd0", 32'hE000_0003);
        next_cycle();
        @(negedge clk);
        check(32'(s_wr[0]));
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_m(3, 1'b0, 1'b1, 30'h0000_0040, 32'hE000_0003, 8'd1);
        @(negedge clk);
        check(32'(s_wr));
        check(32'(m_wait));
        check(32'(m_derr));
        check(32'(s_addr[0 +: AW]));
        next_cycle();
        @(negedge clk);
        check(32'(m_wait));
        check(s_wd[0 +: DW]);
        next_cycle();
        set_m(0, 1'b0, 1'b0, 30'h0, 32'h0, 8'd0);
        @(negedge clk);
        check(32'(s_wr[0]));
        next_cycle();
        @(negedge clk);
        check(32'(m_wait));
        next_cycle();
        @(negedge clk);
        check(32'(m_wait));
        check(s_wd[0 +: DW]);
        next_cycle();
        set_m(3, 1'b0, 1'b0, 30'h0, 32'h0, 8'd0);
        next_cycle();

        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/avalon_xbar_arb.md
Name: avalon_xbar_arb

Overview:
- Parametrised N-input × M-output Avalon-MM crossbar; next generation of the externally-steered crossbar mux.
- Output routing is decoded internally from the upper address bits, not supplied by a mux-select input.
- Each output has its own round-robin arbiter with burst-locked grants.
- Sits between the CPU/DMA masters and the memory/peripheral slaves. Uses the waitrequest-only protocol: read data is valid in the cycle where read=1 and waitrequest=0.

Parameters:
- NUM_INPUTS, 5, number of masters (≥1).
- NUM_OUTPUTS, 5, number of slaves (≥1).
- ADDR_W, 30, word address width.
- DATA_W, 32, data width; ByteEn width is DATA_W/8.
- BURST_W, 8, burstcount width.
- SEL_W (localparam), max(1, clog2(NUM_OUTPUTS)), number of decode bits.

Ports:
- i_Clk, in, 1: clock.
- i_Reset, in, 1: synchronous, active-high reset.
- i_AVIn_Addr, in, ADDR_W*NUM_INPUTS: per-master word address.
- i_AVIn_ByteEn, in, (DATA_W/8)*NUM_INPUTS: per-master byte enables.
- i_AVIn_Read / i_AVIn_Write, in, NUM_INPUTS: per-master read/write strobes.
- i_AVIn_WriteData, in, DATA_W*NUM_INPUTS: per-master write data.
- i_AVIn_BurstCount, in, BURST_W*NUM_INPUTS: per-master burst length.
- o_AVIn_ReadData, out, DATA_W*NUM_INPUTS: per-master read data.
- o_AVIn_WaitRequest, out, NUM_INPUTS: per-master waitrequest.
- o_DecodeErr, out, NUM_INPUTS: one-cycle pulse per unmapped beat.
- o_AVOut_Addr, out, ADDR_W*NUM_OUTPUTS: per-slave address (full address passed through).
- o_AVOut_ByteEn, out, (DATA_W/8)*NUM_OUTPUTS: per-slave byte enables.
- o_AVOut_Read / o_AVOut_Write, out, NUM_OUTPUTS: per-slave strobes.
- o_AVOut_WriteData, out, DATA_W*NUM_OUTPUTS: per-slave write data.
- o_AVOut_BurstCount, out, BURST_W*NUM_OUTPUTS: per-slave burst length.
- i_AVOut_ReadData, in, DATA_W*NUM_OUTPUTS: per-slave read data.
- i_AVOut_WaitRequest, in, NUM_OUTPUTS: per-slave waitrequest.

Behaviour:
- Request: input i requests output o when (Read_i|Write_i) and Addr_i[ADDR_W-1 -: SEL_W]==o.
- Unmapped access (decode value ≥ NUM_OUTPUTS):
  - WaitRequest_i=0 in the same cycle, ReadData_i=0, o_DecodeErr[i]=1 for that cycle.
  - Each burst beat is handled the same way.
- Per-output FSM:
  - IDLE→LOCKED when ≥1 request. Winner is the first requester at or after rr_ptr[o], modulo NUM_INPUTS. The grant is registered, so arbitration latency is 1 cycle.
  - In LOCKED, beat_cnt is loaded with BurstCount of the winner, with 0 treated as 1.
  - LOCKED→IDLE when an accepted beat arrives with beat_cnt==1, or when the granted master drops both Read and Write (abort).
  - On release, rr_ptr[o] = grant+1 (wraps to 0 after NUM_INPUTS-1). The output can re-arbitrate on the following cycle.
- Accepted beat: granted master's (Read|Write) & !i_AVOut_WaitRequest[o]. beat_cnt decrements on each accepted beat.
- Routing while LOCKED:
  - o_AVOut_* carries the granted master's Addr/ByteEn/Read/Write/WriteData/BurstCount combinationally.
  - ReadData_g = i_AVOut_ReadData[o] and WaitRequest_g = i_AVOut_WaitRequest[o].
  - Read/Write are ANDed with "master still decodes to o". A mid-burst address change to another output therefore never leaks.
- While IDLE: o_AVOut_Read/Write=0; Addr/ByteEn/WriteData/BurstCount=0.
- Master not granted anywhere and mapped: WaitRequest_i=1, ReadData_i=0.
- Master granted by at most one output at a time. Grant is only given to a master whose decode targets that output.
- Simultaneous release and new request on the same output: release happens this cycle; new grant the next cycle. A released master is lowest priority in that arbitration.
- Reset (also mid-burst): all grants cleared, FSMs→IDLE, rr_ptr=0, beat_cnt=0. All o_AVOut_Read/Write=0, all o_AVIn_WaitRequest=1, o_DecodeErr=0, all data outputs 0. Reset overrides any beat in that cycle.
- Different outputs operate fully in parallel, with no cross-output coupling.

Test Plan:
- Single read: M0 reads output 2 at addr 0x10000004 (decode 2), slave WaitRequest=0, ReadData=0xCAFEF00D → grant cycle 1, M0 WaitRequest=0 and ReadData=0xCAFEF00D at cycle 1, FSM IDLE at cycle 2.
- Round-robin: M0, M1, M3 all write output 0 continuously, single beats, slave ready → grants M0, M1, M3, M0 in sequence. Non-granted masters see WaitRequest=1 throughout.
- Burst lock: M1 write burst of 4 to output 1 while M2 requests output 1; slave stalls beat 2 for 3 cycles → M2 held until all 4 of M1's beats are accepted, then granted on the next arbitration cycle. BurstCount=0 behaves as 1.
- Parallel and unmapped traffic: M0→out0 and M4→out4 run concurrently without interaction. M2 uses decode value 6 → immediate WaitRequest=0, ReadData=0, one o_DecodeErr[2] pulse per beat.
- Reset mid-burst: assert i_Reset during beat 3 of 8 → next cycle all outputs are in their reset values. After reset, a fresh request from M3 is granted ahead of M0 only if M0 is not requesting (rr_ptr=0).
